sprite_mover: RTL and testbench

- Tile-aware movement engine for the player (and, per instance, ghost) sprite in the Pac-Man datapath.
- Once per video frame it decodes keyboard input into a buffered turn request.
- Through a valid/ready query port it asks the maze logic whether the turn, and then the forward step, are blocked, and commits the new position.
- It adds what the first-generation ball mover lacked:
  - parametrised geometry and step size;
  - turn buffering with grid alignment;
  - wall checks against the maze;
  - optional horizontal tunnel wrap;
  - underflow-safe bound arithmetic.

---
 rtl/sprite_pkg.sv | 37 +++
 rtl/key_dir_decode.sv | 22 ++
 rtl/sprite_mover.sv | 218 +++++++++++++++++++++
 tb/tb_sprite_mover.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite movement engine: directions, FSM states,
// keyboard codes and the reverse-direction helper.
package sprite_pkg;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    UP       = 3'd1,
    DOWN     = 3'd2,
    LEFT     = 3'd3,
    RIGHT    = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN_Q = 2'd1,
    ST_FWD_Q  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      RIGHT:   r = LEFT;
      default: r = DIR_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_dir_decode.sv
// Combinational USB keycode to direction decode; hit_o flags a movement key.
module key_dir_decode
  import sprite_pkg::*;
(
  input  logic [7:0] keycode_i,
  output dir_t       dir_o,
  output logic       hit_o
);

  always_comb begin
    dir_o = DIR_NONE;
    hit_o = 1'b1;
    case (keycode_i)
      KEY_A:   dir_o = LEFT;
      KEY_D:   dir_o = RIGHT;
      KEY_S:   dir_o = DOWN;
      KEY_W:   dir_o = UP;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sprite_mover.sv
// Per-frame sprite movement: buffered turns on tile-aligned positions, wall
// queries to the maze logic, bound checks and optional horizontal wrap.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int W         = 10,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int STEP      = 1,
  parameter int SIZE      = 4,
  parameter int TILE_LOG2 = 3,
  parameter int WRAP_X    = 1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_tick,
  input  logic [7:0]   keycode,
  output logic         q_valid,
  output logic [W-1:0] q_x,
  output logic [W-1:0] q_y,
  input  logic         q_ready,
  input  logic         q_blocked,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [W-1:0] size,
  output dir_t         dir,
  output logic         moving,
  output logic         frame_done,
  output logic         overrun,
  output state_t       dbg_state
);

  // Query handshake: a query is presented while q_valid is high with q_x/q_y
  // held constant; it completes on the first cycle with q_valid & q_ready,
  // which is the only cycle q_blocked is looked at.

  localparam logic signed [W:0] STEP_S  = (W+1)'(STEP);
  localparam logic signed [W:0] X_MIN_S = (W+1)'(X_MIN);
  localparam logic signed [W:0] X_MAX_S = (W+1)'(X_MAX);
  localparam logic signed [W:0] Y_MIN_S = (W+1)'(Y_MIN);
  localparam logic signed [W:0] Y_MAX_S = (W+1)'(Y_MAX);

  typedef struct packed {
    logic         oob;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } cand_t;

  // One sign bit of headroom keeps pos - STEP at pos = 0 negative, not huge.
  function automatic cand_t calc_cand(input dir_t d, input logic [W-1:0] px,
                                      input logic [W-1:0] py);
    logic signed [W:0] sx;
    logic signed [W:0] sy;
    cand_t c;
    sx    = signed'({1'b0, px});
    sy    = signed'({1'b0, py});
    c.oob = 1'b0;
    case (d)
      LEFT:    sx = sx - STEP_S;
      RIGHT:   sx = sx + STEP_S;
      UP:      sy = sy - STEP_S;
      DOWN:    sy = sy + STEP_S;
      default: ;
    endcase
    if (sy < Y_MIN_S || sy > Y_MAX_S) c.oob = 1'b1;
    if (sx < X_MIN_S) begin
      if (WRAP_X != 0) sx = X_MAX_S;
      else c.oob = 1'b1;
    end else if (sx > X_MAX_S) begin
      if (WRAP_X != 0) sx = X_MIN_S;
      else c.oob = 1'b1;
    end
    c.x = sx[W-1:0];
    c.y = sy[W-1:0];
    return c;
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  state_t       state_q, state_d;
  dir_t         dir_q, dir_d, pend_q, pend_d, turn_q, turn_d;
  logic [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic         moving_q, moving_d, done_q, done_d, ovr_q, ovr_d;
  logic         adopt, key_hit, turn_aligned;
  dir_t         key_dir;
  cand_t        turn_c, fwd_c;

  key_dir_decode u_dec (
    .keycode_i (keycode),
    .dir_o     (key_dir),
    .hit_o     (key_hit)
  );

  assign turn_c = calc_cand(turn_q, pos_x_q, pos_y_q);
  assign fwd_c  = calc_cand(dir_q, pos_x_q, pos_y_q);

  // A vertical turn needs X on the grid and vice versa.
  assign turn_aligned = (pend_q == UP || pend_q == DOWN) ?
                        (pos_x_q[TILE_LOG2-1:0] == '0) :
                        (pos_y_q[TILE_LOG2-1:0] == '0);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    turn_d   = turn_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    moving_d = moving_q;
    done_d   = 1'b0;
    adopt    = 1'b0;
    ovr_d    = ovr_q | (frame_tick && state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_FWD_Q;
          if (pend_q == DIR_NONE || pend_q == dir_q) begin
            adopt = 1'b1;
          end else if (pend_q == opposite(dir_q) || dir_q == DIR_NONE) begin
            dir_d = pend_q;
            adopt = 1'b1;
          end else if (turn_aligned) begin
            turn_d  = pend_q;
            state_d = ST_TURN_Q;
          end
        end
      end
      ST_TURN_Q: begin
        if (turn_c.oob) begin
          state_d = ST_FWD_Q;
        end else if (q_ready) begin
          if (!q_blocked) begin
            dir_d = turn_q;
            adopt = (pend_q == turn_q);
          end
          state_d = ST_FWD_Q;
        end
      end
      ST_FWD_Q: begin
        if (dir_q == DIR_NONE || fwd_c.oob) begin
          nx_d    = pos_x_q;
          ny_d    = pos_y_q;
          state_d = ST_COMMIT;
        end else if (q_ready) begin
          nx_d    = q_blocked ? pos_x_q : fwd_c.x;
          ny_d    = q_blocked ? pos_y_q : fwd_c.y;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        pos_x_d  = nx_q;
        pos_y_d  = ny_q;
        moving_d = (nx_q != pos_x_q) || (ny_q != pos_y_q);
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A key seen in the same cycle as an adoption wins over the clear.
    pend_d = adopt ? DIR_NONE : pend_q;
    if (key_hit) pend_d = key_dir;
  end

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_NONE;
      pend_q   <= DIR_NONE;
      turn_q   <= DIR_NONE;
      pos_x_q  <= W'(X_CENTER);
      pos_y_q  <= W'(Y_CENTER);
      nx_q     <= W'(X_CENTER);
      ny_q     <= W'(Y_CENTER);
      moving_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      turn_q   <= turn_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      moving_q <= moving_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign q_valid    = (state_q == ST_TURN_Q && !turn_c.oob) ||
                      (state_q == ST_FWD_Q && dir_q != DIR_NONE && !fwd_c.oob);
  assign q_x        = (state_q == ST_TURN_Q) ? turn_c.x : fwd_c.x;
  assign q_y        = (state_q == ST_TURN_Q) ? turn_c.y : fwd_c.y;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign size       = W'(SIZE);
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: frames and maze queries are predicted into
// queues and checked by a monitor whenever the DUT raises frame_done / q_valid.
module tb_sprite_mover;
  import sprite_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0, q_ready = 1'b1, q_blocked = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       q_valid, moving, frame_done, overrun;
  logic [9:0] q_x, q_y, pos_x, pos_y, size;
  dir_t       dir;
  state_t     dbg_state;

  logic       frame_tick_e = 1'b0, q_ready_e = 1'b1, q_blocked_e = 1'b0;
  logic [7:0] keycode_e = 8'h00;
  logic       q_valid_e, moving_e, frame_done_e, overrun_e;
  logic [9:0] q_x_e, q_y_e, pos_x_e, pos_y_e, size_e;
  dir_t       dir_e;
  state_t     dbg_state_e;

  sprite_mover dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
    .q_valid(q_valid), .q_x(q_x), .q_y(q_y), .q_ready(q_ready), .q_blocked(q_blocked),
    .pos_x(pos_x), .pos_y(pos_y), .size(size), .dir(dir), .moving(moving),
    .frame_done(frame_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  sprite_mover #(.X_CENTER(0), .Y_CENTER(0), .WRAP_X(0)) dut_e (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick_e), .keycode(keycode_e),
    .q_valid(q_valid_e), .q_x(q_x_e), .q_y(q_y_e), .q_ready(q_ready_e), .q_blocked(q_blocked_e),
    .pos_x(pos_x_e), .pos_y(pos_y_e), .size(size_e), .dir(dir_e), .moving(moving_e),
    .frame_done(frame_done_e), .overrun(overrun_e), .dbg_state(dbg_state_e)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         d;
    logic       mov;
    logic       ovr;
    int         due;
  } fexp_t;

  fexp_t       frame_q[$];
  logic [19:0] exp_q[$];
  fexp_t       mon_e;
  int          total = 0;
  int          bad = 0;
  int          qv_e_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: actual=%0d required=none (cycle %0d)", name, act, cyc);
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (q_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_query", {q_x, q_y});
        else begin
          chk("query_xy", {q_x, q_y}, exp_q[0]);
          if (q_ready) void'(exp_q.pop_front());
        end
      end
      if (frame_done) begin
        if (frame_q.size() == 0) fail_now("unexpected_frame_done", pos_x);
        else begin
          mon_e = frame_q.pop_front();
          chk("pos_x", pos_x, mon_e.x);
          chk("pos_y", pos_y, mon_e.y);
          chk("dir", dir, mon_e.d);
          chk("moving", moving, mon_e.mov);
          chk("overrun", overrun, mon_e.ovr);
          chk("done_cycle", cyc, mon_e.due);
        end
      end
      if (q_valid_e) qv_e_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic qpush(input logic [9:0] x, input logic [9:0] y);
    exp_q.push_back({x, y});
  endtask

  task automatic fpush(input logic [9:0] x, input logic [9:0] y, input dir_t d,
                       input logic mov, input logic ovr, input int lat);
    fexp_t e;
    e.x = x; e.y = y; e.d = d; e.mov = mov; e.ovr = ovr; e.due = cyc + lat;
    frame_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (frame_q.size() == 0) break;
      next_cycle();
    end
    if (frame_q.size() != 0) begin
      fail_now("frame_timeout", frame_q.size());
      frame_q.delete();
    end
    chk("queries_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic frame_go(input logic [9:0] x, input logic [9:0] y, input dir_t d,
                          input logic mov, input logic ovr, input int lat);
    fpush(x, y, d, mov, ovr, lat);
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    wait_done();
  endtask

  task automatic key(input logic [7:0] k);
    keycode = k;
    next_cycle();
    keycode = 8'h00;
  endtask

  task automatic edge_frame(input string tag, input int lat, input dir_t d);
    int t0;
    int seen;
    t0 = cyc;
    seen = -1;
    frame_tick_e = 1'b1;
    next_cycle();
    frame_tick_e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done_e) begin
        seen = cyc;
        break;
      end
      next_cycle();
    end
    chk({tag, "_latency"}, seen - t0, lat);
    chk({tag, "_pos_x"}, pos_x_e, 0);
    chk({tag, "_pos_y"}, pos_y_e, 0);
    chk({tag, "_dir"}, dir_e, d);
    chk({tag, "_moving"}, moving_e, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) next_cycle();
    Reset_n = 1'b1;
    repeat (3) next_cycle();
    chk("rst_pos_x", pos_x, 320);
    chk("rst_pos_y", pos_y, 240);
    chk("rst_dir", dir, DIR_NONE);
    chk("rst_moving", moving, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("size", size, 4);

    // Hold RIGHT: first frame adopts it without a turn query.
    keycode = KEY_D;
    next_cycle();
    for (int x = 320; x <= 322; x++) begin
      qpush(10'(x + 1), 240);
      frame_go(10'(x + 1), 240, RIGHT, 1'b1, 1'b0, 3);
    end
    keycode = 8'h00;

    // UP buffered at x=323, taken only once x reaches 328.
    key(KEY_W);
    for (int x = 323; x <= 327; x++) begin
      qpush(10'(x + 1), 240);
      frame_go(10'(x + 1), 240, RIGHT, 1'b1, 1'b0, 3);
    end
    qpush(328, 239);
    qpush(328, 239);
    frame_go(328, 239, UP, 1'b1, 1'b0, 4);

    // LEFT buffered, waits for y=232.
    key(KEY_A);
    for (int y = 239; y >= 233; y--) begin
      qpush(328, 10'(y - 1));
      frame_go(328, 10'(y - 1), UP, 1'b1, 1'b0, 3);
    end
    // Both queries blocked, turn answer delayed 5 cycles.
    qpush(327, 232);
    qpush(328, 231);
    fpush(328, 232, UP, 1'b0, 1'b0, 9);
    q_ready = 1'b0;
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    repeat (5) next_cycle();
    q_ready = 1'b1;
    q_blocked = 1'b1;
    wait_done();
    q_blocked = 1'b0;
    // Retained LEFT adopted on the next open frame.
    qpush(327, 232);
    qpush(327, 232);
    frame_go(327, 232, LEFT, 1'b1, 1'b0, 4);

    // Second tick while stalled in the forward query.
    qpush(326, 232);
    fpush(326, 232, LEFT, 1'b1, 1'b1, 4);
    q_ready = 1'b0;
    frame_tick = 1'b1;
    next_cycle();
    next_cycle();
    frame_tick = 1'b0;
    q_ready = 1'b1;
    wait_done();
    repeat (4) next_cycle();
    chk("single_commit", frame_q.size(), 0);

    // Walk left to x=0, then wrap to 639.
    for (int x = 326; x >= 1; x--) begin
      qpush(10'(x - 1), 232);
      frame_go(10'(x - 1), 232, LEFT, 1'b1, 1'b1, 3);
    end
    qpush(639, 232);
    frame_go(639, 232, LEFT, 1'b1, 1'b1, 3);

    // DOWN buffered until x=632, then reset in the middle of the turn query.
    key(KEY_S);
    for (int x = 639; x >= 633; x--) begin
      qpush(10'(x - 1), 232);
      frame_go(10'(x - 1), 232, LEFT, 1'b1, 1'b1, 3);
    end
    qpush(632, 233);
    q_ready = 1'b0;
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    next_cycle();
    chk("turn_q_state", dbg_state, ST_TURN_Q);
    chk("turn_q_valid", q_valid, 1);
    chk("turn_q_y", q_y, 233);
    Reset_n = 1'b0;
    #1;
    chk("rst_drops_q_valid", q_valid, 0);
    exp_q.delete();
    frame_q.delete();
    next_cycle();
    Reset_n = 1'b1;
    q_ready = 1'b1;
    repeat (3) next_cycle();
    chk("rst2_pos_x", pos_x, 320);
    chk("rst2_pos_y", pos_y, 240);
    chk("rst2_dir", dir, DIR_NONE);
    chk("rst2_overrun", overrun, 0);
    chk("rst2_q_valid", q_valid, 0);

    // Bound instance at (0,0) without wrap: no query may ever be issued.
    keycode_e = KEY_W;
    next_cycle();
    keycode_e = 8'h00;
    edge_frame("ymin_up", 3, UP);
    keycode_e = KEY_A;
    next_cycle();
    keycode_e = 8'h00;
    edge_frame("xmin_nowrap", 4, UP);
    chk("edge_query_count", qv_e_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=%0d required=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
